traffic_ctrl: RTL and testbench

//  Multi-lane traffic generator for the road section of the game grid. Owns one
//  car per lane; each lane has its own speed divider, direction and start column.
//  A shared, level-scaled step prescaler paces all lanes. Feeds the sprite/render

---
 rtl/traffic_ctrl_pkg.sv | 24 ++
 rtl/traffic_ctrl_lane_mover.sv | 71 +++++++
 rtl/traffic_ctrl.sv | 96 +++++++++
 tb/tb_traffic_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_ctrl_pkg.sv
// Shared types, default lane tables and helpers for the road-section traffic generator.
package traffic_ctrl_pkg;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } lane_dir_e;

    localparam int unsigned DIV_W         = 4;
    localparam int unsigned DEF_NUM_LANES = 4;
    localparam int unsigned DEF_COORD_W   = 6;

    localparam logic [DEF_NUM_LANES*DIV_W-1:0]       DEF_LANE_DIV = 16'h1232;
    localparam logic [DEF_NUM_LANES-1:0]             DEF_LANE_DIR = 4'b1010;
    localparam logic [DEF_NUM_LANES*DEF_COORD_W-1:0] DEF_INIT_X   =
        {6'd12, 6'd5, 6'd17, 6'd0};

    // Base period after level scaling, never allowed below the floor.
    function automatic logic [31:0] clamp_period(input logic [31:0] scaled,
                                                 input logic [31:0] floor_p);
        return (scaled < floor_p) ? floor_p : scaled;
    endfunction

endpackage

// File: rtl/traffic_ctrl_lane_mover.sv
// One car: per-lane step divider, wrapping X position and registered step strobe.
module lane_mover
    import traffic_ctrl_pkg::*;
#(
    parameter int unsigned           c_COORD_W = 6,
    parameter int unsigned           c_MAX_X   = 20,
    parameter int unsigned           c_DIV     = 1,
    parameter lane_dir_e             c_DIR     = DIR_RIGHT,
    parameter logic [c_COORD_W-1:0]  c_INIT_X  = '0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Tick,
    input  logic                 i_Restart,
    input  logic                 i_Pause,
    output logic [c_COORD_W-1:0] o_X,
    output logic                 o_Step
);

    localparam int unsigned          DIV_EFF  = (c_DIV == 0) ? 1 : c_DIV;
    localparam logic [DIV_W-1:0]     CNT_LAST = DIV_W'(DIV_EFF - 1);
    localparam logic [c_COORD_W-1:0] X_LAST   = c_COORD_W'(c_MAX_X - 1);
    localparam logic [c_COORD_W-1:0] X_ONE    = c_COORD_W'(1);

    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [c_COORD_W-1:0] x_q, x_d, x_next;
    logic                 step_q, step_d;

    always_comb begin
        x_next = x_q;
        if (c_DIR == DIR_LEFT) begin
            x_next = (x_q == '0) ? X_LAST : x_q - X_ONE;
        end else begin
            x_next = (x_q >= X_LAST) ? '0 : x_q + X_ONE;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        step_d = 1'b0;
        if (i_Restart) begin
            cnt_d = '0;
            x_d   = c_INIT_X;
        end else if (!i_Pause && i_Tick) begin
            if (cnt_q >= CNT_LAST) begin
                cnt_d  = '0;
                x_d    = x_next;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q  <= '0;
            x_q    <= c_INIT_X;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            step_q <= step_d;
        end
    end

    assign o_X    = x_q;
    assign o_Step = step_q;

endmodule

// File: rtl/traffic_ctrl.sv
// Multi-lane traffic generator: level-scaled shared prescaler driving one lane_mover per lane.
module traffic_ctrl
    import traffic_ctrl_pkg::*;
#(
    parameter int unsigned                         c_NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned                         c_COORD_W   = DEF_COORD_W,
    parameter int unsigned                         c_MAX_X     = 20,
    parameter int unsigned                         c_BASE_TICK = 4000000,
    parameter int unsigned                         c_MIN_TICK  = 250000,
    parameter int unsigned                         c_LEVEL_W   = 3,
    parameter int unsigned                         c_FIRST_Y   = 10,
    parameter logic [c_NUM_LANES*DIV_W-1:0]        c_LANE_DIV  = DEF_LANE_DIV,
    parameter logic [c_NUM_LANES-1:0]              c_LANE_DIR  = DEF_LANE_DIR,
    parameter logic [c_NUM_LANES*c_COORD_W-1:0]    c_INIT_X    = DEF_INIT_X
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_L,
    input  logic                             i_Restart,
    input  logic                             i_Pause,
    input  logic [c_LEVEL_W-1:0]             i_Level,
    output logic [c_NUM_LANES*c_COORD_W-1:0] o_Car_X,
    output logic [c_NUM_LANES*c_COORD_W-1:0] o_Car_Y,
    output logic [c_NUM_LANES-1:0]           o_Step,
    output logic                             o_Base_Tick
);

    localparam logic [31:0] BASE_32 = 32'(c_BASE_TICK);
    localparam logic [31:0] MIN_32  = 32'(c_MIN_TICK);

    logic [31:0] period;
    logic [31:0] period_m1;
    logic [31:0] presc_q, presc_d;
    logic        tick_q, tick_d;

    always_comb begin
        period    = clamp_period(BASE_32 >> i_Level, MIN_32);
        period_m1 = period - 32'd1;
    end

    // ">=" rather than "==" so a level raise mid-count fires on the next
    // evaluation instead of running on to a counter wrap.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (i_Restart) begin
            presc_d = '0;
        end else if (!i_Pause) begin
            if (presc_q >= period_m1) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign o_Base_Tick = tick_q;

    // Lanes consume the unregistered wrap strobe so each lane's move lands
    // in the same cycle as the registered o_Base_Tick pulse.
    for (genvar n = 0; n < c_NUM_LANES; n++) begin : gen_lane
        logic [c_COORD_W-1:0] lane_x;
        logic                 lane_step;

        lane_mover #(
            .c_COORD_W (c_COORD_W),
            .c_MAX_X   (c_MAX_X),
            .c_DIV     (32'(c_LANE_DIV[n*DIV_W +: DIV_W])),
            .c_DIR     (lane_dir_e'(c_LANE_DIR[n])),
            .c_INIT_X  (c_INIT_X[n*c_COORD_W +: c_COORD_W])
        ) u_lane (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .i_Tick    (tick_d),
            .i_Restart (i_Restart),
            .i_Pause   (i_Pause),
            .o_X       (lane_x),
            .o_Step    (lane_step)
        );

        assign o_Car_X[n*c_COORD_W +: c_COORD_W] = lane_x;
        assign o_Car_Y[n*c_COORD_W +: c_COORD_W] = c_COORD_W'(c_FIRST_Y + n);
        assign o_Step[n]                         = lane_step;
    end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: 2 lanes, base period 8, floor 2, grid width 5.
module tb_traffic_ctrl;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        restart = 1'b0;
    logic        pause   = 1'b0;
    logic [2:0]  level   = 3'd0;
    logic [11:0] car_x;
    logic [11:0] car_y;
    logic [1:0]  step;
    logic        base_tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_ctrl #(
        .c_NUM_LANES (2),
        .c_COORD_W   (6),
        .c_MAX_X     (5),
        .c_BASE_TICK (8),
        .c_MIN_TICK  (2),
        .c_LEVEL_W   (3),
        .c_FIRST_Y   (10),
        .c_LANE_DIV  (8'h21),
        .c_LANE_DIR  (2'b10),
        .c_INIT_X    (12'h003)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Restart   (restart),
        .i_Pause     (pause),
        .i_Level     (level),
        .o_Car_X     (car_x),
        .o_Car_Y     (car_y),
        .o_Step      (step),
        .o_Base_Tick (base_tick)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) clk_step();
        n_cmp++;
        if (car_x !== 12'h003) begin
            n_bad++; $display("FAIL reset_x: got %h expected %h", car_x, 12'h003);
        end
        n_cmp++;
        if (car_y !== {6'd11, 6'd10}) begin
            n_bad++; $display("FAIL reset_y: got %h expected %h", car_y, {6'd11, 6'd10});
        end
        n_cmp++;
        if (step !== 2'b00) begin
            n_bad++; $display("FAIL reset_step: got %b expected 00", step);
        end
        n_cmp++;
        if (base_tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_tick: got %b expected 0", base_tick);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_level0();
        logic [5:0]  x0_tbl [4] = '{6'd4, 6'd0, 6'd1, 6'd2};
        logic [5:0]  x1_tbl [4] = '{6'd0, 6'd4, 6'd4, 6'd3};
        logic        exp_tick;
        logic [1:0]  exp_step;
        logic [11:0] exp_x;
        level = 3'd0;
        for (int e = 1; e <= 32; e++) begin
            clk_step();
            exp_tick = (e % 8 == 0);
            exp_step = {(e % 16 == 0), (e % 8 == 0)};
            n_cmp++;
            if (base_tick !== exp_tick) begin
                n_bad++; $display("FAIL lvl0_tick e=%0d: got %b expected %b", e, base_tick, exp_tick);
            end
            n_cmp++;
            if (step !== exp_step) begin
                n_bad++; $display("FAIL lvl0_step e=%0d: got %b expected %b", e, step, exp_step);
            end
            if (e % 8 == 0) begin
                exp_x = {x1_tbl[e/8-1], x0_tbl[e/8-1]};
                n_cmp++;
                if (car_x !== exp_x) begin
                    n_bad++; $display("FAIL lvl0_x e=%0d: got %h expected %h", e, car_x, exp_x);
                end
            end
        end
    endtask

    task automatic test_level_scale(input logic [2:0] lvl, input logic [11:0] x_end);
        logic       exp_tick;
        logic [1:0] exp_step;
        level = lvl;
        for (int e = 1; e <= 4; e++) begin
            clk_step();
            exp_tick = (e % 2 == 0);
            exp_step = (e == 2) ? 2'b01 : (e == 4) ? 2'b11 : 2'b00;
            n_cmp++;
            if (base_tick !== exp_tick) begin
                n_bad++; $display("FAIL lvl%0d_tick e=%0d: got %b expected %b", lvl, e, base_tick, exp_tick);
            end
            n_cmp++;
            if (step !== exp_step) begin
                n_bad++; $display("FAIL lvl%0d_step e=%0d: got %b expected %b", lvl, e, step, exp_step);
            end
        end
        n_cmp++;
        if (car_x !== x_end) begin
            n_bad++; $display("FAIL lvl%0d_x: got %h expected %h", lvl, car_x, x_end);
        end
    endtask

    task automatic test_level_switch();
        level = 3'd0;
        for (int e = 1; e <= 6; e++) begin
            clk_step();
            n_cmp++;
            if (base_tick !== 1'b0) begin
                n_bad++; $display("FAIL switch_pre_tick e=%0d: got %b expected 0", e, base_tick);
            end
        end
        level = 3'd2;
        clk_step();
        n_cmp++;
        if (base_tick !== 1'b1) begin
            n_bad++; $display("FAIL switch_tick: got %b expected 1", base_tick);
        end
        n_cmp++;
        if (step !== 2'b01) begin
            n_bad++; $display("FAIL switch_step: got %b expected 01", step);
        end
        n_cmp++;
        if (car_x !== {6'd1, 6'd2}) begin
            n_bad++; $display("FAIL switch_x: got %h expected %h", car_x, {6'd1, 6'd2});
        end
        level = 3'd0;
    endtask

    task automatic test_pause();
        logic exp_tick;
        repeat (3) clk_step();
        pause = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            clk_step();
            n_cmp++;
            if (base_tick !== 1'b0 || step !== 2'b00) begin
                n_bad++; $display("FAIL pause_strobe e=%0d: got tick=%b step=%b expected 0/00", e, base_tick, step);
            end
            n_cmp++;
            if (car_x !== {6'd1, 6'd2}) begin
                n_bad++; $display("FAIL pause_x e=%0d: got %h expected %h", e, car_x, {6'd1, 6'd2});
            end
        end
        pause = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            clk_step();
            exp_tick = (e == 5);
            n_cmp++;
            if (base_tick !== exp_tick) begin
                n_bad++; $display("FAIL resume_tick e=%0d: got %b expected %b", e, base_tick, exp_tick);
            end
        end
        n_cmp++;
        if (step !== 2'b11) begin
            n_bad++; $display("FAIL resume_step: got %b expected 11", step);
        end
        n_cmp++;
        if (car_x !== {6'd0, 6'd3}) begin
            n_bad++; $display("FAIL resume_x: got %h expected %h", car_x, {6'd0, 6'd3});
        end
    endtask

    task automatic test_restart();
        logic exp_tick;
        repeat (8) clk_step();
        n_cmp++;
        if (car_x !== {6'd0, 6'd4} || step !== 2'b01) begin
            n_bad++; $display("FAIL prerestart: got x=%h step=%b expected %h/01", car_x, step, {6'd0, 6'd4});
        end
        repeat (7) clk_step();
        restart = 1'b1;
        clk_step();
        restart = 1'b0;
        n_cmp++;
        if (step !== 2'b00) begin
            n_bad++; $display("FAIL restart_step: got %b expected 00", step);
        end
        n_cmp++;
        if (base_tick !== 1'b0) begin
            n_bad++; $display("FAIL restart_tick: got %b expected 0", base_tick);
        end
        n_cmp++;
        if (car_x !== 12'h003) begin
            n_bad++; $display("FAIL restart_x: got %h expected %h", car_x, 12'h003);
        end
        for (int e = 1; e <= 8; e++) begin
            clk_step();
            exp_tick = (e == 8);
            n_cmp++;
            if (base_tick !== exp_tick) begin
                n_bad++; $display("FAIL postrestart_tick e=%0d: got %b expected %b", e, base_tick, exp_tick);
            end
        end
        n_cmp++;
        if (step !== 2'b01) begin
            n_bad++; $display("FAIL postrestart_step: got %b expected 01", step);
        end
        n_cmp++;
        if (car_x !== {6'd0, 6'd4}) begin
            n_bad++; $display("FAIL postrestart_x: got %h expected %h", car_x, {6'd0, 6'd4});
        end
    endtask

    task automatic test_async_reset();
        logic exp_tick;
        repeat (3) clk_step();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (car_x !== 12'h003) begin
            n_bad++; $display("FAIL async_x: got %h expected %h", car_x, 12'h003);
        end
        n_cmp++;
        if (step !== 2'b00 || base_tick !== 1'b0) begin
            n_bad++; $display("FAIL async_strobe: got step=%b tick=%b expected 00/0", step, base_tick);
        end
        clk_step();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            clk_step();
            exp_tick = (e == 8);
            n_cmp++;
            if (base_tick !== exp_tick) begin
                n_bad++; $display("FAIL postasync_tick e=%0d: got %b expected %b", e, base_tick, exp_tick);
            end
        end
        n_cmp++;
        if (step !== 2'b01) begin
            n_bad++; $display("FAIL postasync_step: got %b expected 01", step);
        end
        n_cmp++;
        if (car_x !== {6'd0, 6'd4}) begin
            n_bad++; $display("FAIL postasync_x: got %h expected %h", car_x, {6'd0, 6'd4});
        end
        n_cmp++;
        if (car_y !== {6'd11, 6'd10}) begin
            n_bad++; $display("FAIL postasync_y: got %h expected %h", car_y, {6'd11, 6'd10});
        end
    endtask

    initial begin
        test_reset();
        test_level0();
        test_level_scale(3'd2, {6'd2, 6'd4});
        test_level_scale(3'd7, {6'd1, 6'd1});
        test_level_switch();
        test_pause();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
